// File: rtl/timer_key_pkg.sv
// Shared types and default constants for the front-panel key conditioner.
// Optional auto-repeat is enabled by defining TIMER_KEY_AUTOREPEAT_EN.
package timer_key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_N_KEYS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_DELAY    = 20;
  localparam int unsigned DEF_REPEAT_RATE     = 5;

  localparam int unsigned KEY_SET_TIME = 0;
  localparam int unsigned KEY_ALARM    = 1;
  localparam int unsigned KEY_HOURS    = 2;
  localparam int unsigned KEY_MINS     = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/timer_key_channel.sv
// One key channel: 2-flop synchroniser, debounce, press pulse and optional
// auto-repeat (compiled in when TIMER_KEY_AUTOREPEAT_EN is defined).
module timer_key_channel
  import timer_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef TIMER_KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_pulse
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;
  logic            rpt_fire;

  // Synchroniser and debounce: accept s2 after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    s1_d     = key_raw;
    s2_d     = s1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s2_q;
        press   = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef TIMER_KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = '1;

  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_inc;

  assign rpt_cnt_inc = (rpt_cnt_q == RPT_MAX) ? rpt_cnt_q : rpt_cnt_q + RPT_W'(1);

  // Repeat FSM: leaves to IDLE whenever the debounced level is (about to be) 0.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (!level_d) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            state_d   = WAIT;
            rpt_cnt_d = '0;
          end
        end
        WAIT: begin
          if (rpt_cnt_q >= RPT_W'(REPEAT_DELAY - 1)) begin
            rpt_fire  = 1'b1;
            state_d   = REPEAT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_inc;
          end
        end
        REPEAT: begin
          if (rpt_cnt_q >= RPT_W'(REPEAT_RATE - 1)) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_inc;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign pulse_d = press | rpt_fire;

  // Synchroniser, debounce and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign key_level = level_q;
  assign key_pulse = pulse_q;

endmodule

// File: rtl/timer_key_conditioner.sv
// Front-panel key conditioner: N_KEYS independent debounced channels feeding
// the alarm-clock timer. Auto-repeat is enabled by TIMER_KEY_AUTOREPEAT_EN.
module timer_key_conditioner
  import timer_key_pkg::*;
#(
  parameter int unsigned N_KEYS          = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse
);

  // Reject zero-length debounce or repeat intervals at elaboration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("timer_key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  // One identical channel per key.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    timer_key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef TIMER_KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_raw  (key_raw[k]),
      .key_level(key_level[k]),
      .key_pulse(key_pulse[k])
    );
  end

endmodule
